alu_2_pc_1: RTL and testbench

Execute-stage datapath block for the single-cycle MIPS-I Harvard CPU. It holds the program counter register (PC_1 function) and the PC+4 and branch-target adders (Add_ALU function). It also contains the main ALU with its HI/LO register pair (ALU_2 function): result generation, branch-condition evaluation, multiply/divide. The control unit, register file and next-PC muxes (jump/JR selection) sit outside and feed `PCin` back in.

---
 rtl/alu_2_pc_1.sv | 217 +++++++++++++++++++++
 tb/tb_alu_2_pc_1.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_2_pc_1.sv
// ---------------------------------------------------------------------------
// Module   : alu_2_pc_1
// Brief    : MIPS-I execute stage: PC register, PC+4/branch adders, ALU, HI/LO
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_2_pc_1 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] PCin,
  output logic [31:0] PCout,
  output logic [31:0] PCplus4,
  input  logic [5:0]  opcode,
  input  logic [5:0]  functcode,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt_field,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic [31:0] ALU_result,
  output logic        sig_branch,
  output logic [31:0] branch_address,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;

  localparam logic [5:0] c_op_rtype  = 6'h00;
  localparam logic [5:0] c_op_regimm = 6'h01;
  localparam logic [5:0] c_op_jal    = 6'h03;
  localparam logic [5:0] c_op_beq    = 6'h04;
  localparam logic [5:0] c_op_bne    = 6'h05;
  localparam logic [5:0] c_op_blez   = 6'h06;
  localparam logic [5:0] c_op_bgtz   = 6'h07;
  localparam logic [5:0] c_op_addi   = 6'h08;
  localparam logic [5:0] c_op_addiu  = 6'h09;
  localparam logic [5:0] c_op_slti   = 6'h0A;
  localparam logic [5:0] c_op_sltiu  = 6'h0B;
  localparam logic [5:0] c_op_andi   = 6'h0C;
  localparam logic [5:0] c_op_ori    = 6'h0D;
  localparam logic [5:0] c_op_xori   = 6'h0E;
  localparam logic [5:0] c_op_lui    = 6'h0F;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_srl   = 6'h02;
  localparam logic [5:0] c_fn_sra   = 6'h03;
  localparam logic [5:0] c_fn_sllv  = 6'h04;
  localparam logic [5:0] c_fn_srlv  = 6'h06;
  localparam logic [5:0] c_fn_srav  = 6'h07;
  localparam logic [5:0] c_fn_jalr  = 6'h09;
  localparam logic [5:0] c_fn_mfhi  = 6'h10;
  localparam logic [5:0] c_fn_mthi  = 6'h11;
  localparam logic [5:0] c_fn_mflo  = 6'h12;
  localparam logic [5:0] c_fn_mtlo  = 6'h13;
  localparam logic [5:0] c_fn_mult  = 6'h18;
  localparam logic [5:0] c_fn_multu = 6'h19;
  localparam logic [5:0] c_fn_div   = 6'h1A;
  localparam logic [5:0] c_fn_divu  = 6'h1B;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_addu  = 6'h21;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_subu  = 6'h23;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_xor   = 6'h26;
  localparam logic [5:0] c_fn_nor   = 6'h27;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [5:0] c_fn_sltu  = 6'h2B;

  logic [31:0] r_pc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_link;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_zero;
  logic [31:0] w_divisor;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;
  logic        w_rs_neg;
  logic        w_rs_zero;

  assign w_sext  = {{16{immediate[15]}}, immediate};
  assign w_zext  = {16'h0000, immediate};
  assign PCout   = r_pc;
  assign PCplus4 = r_pc + 32'd4;
  assign w_link  = PCplus4 + 32'd4;
  assign branch_address = PCplus4 + {w_sext[29:0], 2'b00};
  assign HI = r_hi;
  assign LO = r_lo;

  assign w_rs_neg  = rs_content[31];
  assign w_rs_zero = (rs_content == 32'h0);

  // Products are always computed; the HI/LO write selects which one lands.
  assign w_prod_s = $signed({{32{rs_content[31]}}, rs_content}) *
                    $signed({{32{rt_content[31]}}, rt_content});
  assign w_prod_u = {32'h0, rs_content} * {32'h0, rt_content};

  // A zero divisor is replaced so the divider never sees /0; the write is suppressed anyway.
  assign w_div_zero = (rt_content == 32'h0);
  assign w_divisor  = w_div_zero ? 32'd1 : rt_content;
  assign w_quot_s   = $signed(rs_content) / $signed(w_divisor);
  assign w_rem_s    = $signed(rs_content) % $signed(w_divisor);
  assign w_quot_u   = rs_content / w_divisor;
  assign w_rem_u    = rs_content % w_divisor;

  always_comb begin
    ALU_result = 32'h0;
    case (opcode)
      c_op_rtype: begin
        case (functcode)
          c_fn_sll:  ALU_result = rt_content << shamt;
          c_fn_srl:  ALU_result = rt_content >> shamt;
          c_fn_sra:  ALU_result = $signed(rt_content) >>> shamt;
          c_fn_sllv: ALU_result = rt_content << rs_content[4:0];
          c_fn_srlv: ALU_result = rt_content >> rs_content[4:0];
          c_fn_srav: ALU_result = $signed(rt_content) >>> rs_content[4:0];
          c_fn_jalr: ALU_result = w_link;
          c_fn_mfhi: ALU_result = r_hi;
          c_fn_mflo: ALU_result = r_lo;
          c_fn_add, c_fn_addu: ALU_result = rs_content + rt_content;
          c_fn_sub, c_fn_subu: ALU_result = rs_content - rt_content;
          c_fn_and:  ALU_result = rs_content & rt_content;
          c_fn_or:   ALU_result = rs_content | rt_content;
          c_fn_xor:  ALU_result = rs_content ^ rt_content;
          c_fn_nor:  ALU_result = ~(rs_content | rt_content);
          c_fn_slt:  ALU_result = {31'h0, $signed(rs_content) < $signed(rt_content)};
          c_fn_sltu: ALU_result = {31'h0, rs_content < rt_content};
          default:   ALU_result = 32'h0;
        endcase
      end
      c_op_regimm: ALU_result = rt_field[4] ? w_link : 32'h0;
      c_op_jal:    ALU_result = w_link;
      c_op_addi, c_op_addiu: ALU_result = rs_content + w_sext;
      c_op_slti:   ALU_result = {31'h0, $signed(rs_content) < $signed(w_sext)};
      c_op_sltiu:  ALU_result = {31'h0, rs_content < w_sext};
      c_op_andi:   ALU_result = rs_content & w_zext;
      c_op_ori:    ALU_result = rs_content | w_zext;
      c_op_xori:   ALU_result = rs_content ^ w_zext;
      c_op_lui:    ALU_result = {immediate, 16'h0000};
      default: begin
        if (opcode >= 6'h20 && opcode <= 6'h2E) ALU_result = rs_content + w_sext;
      end
    endcase
  end

  always_comb begin
    sig_branch = 1'b0;
    case (opcode)
      c_op_beq:  sig_branch = (rs_content == rt_content);
      c_op_bne:  sig_branch = (rs_content != rt_content);
      c_op_blez: sig_branch = w_rs_neg | w_rs_zero;
      c_op_bgtz: sig_branch = ~w_rs_neg & ~w_rs_zero;
      c_op_regimm: begin
        case (rt_field)
          5'h00, 5'h10: sig_branch = w_rs_neg;
          5'h01, 5'h11: sig_branch = ~w_rs_neg;
          default:      sig_branch = 1'b0;
        endcase
      end
      default: sig_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= c_reset_pc;
    end else if (clk_enable) begin
      r_pc <= PCin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (clk_enable && opcode == c_op_rtype) begin
      case (functcode)
        c_fn_mult: begin
          r_hi <= w_prod_s[63:32];
          r_lo <= w_prod_s[31:0];
        end
        c_fn_multu: begin
          r_hi <= w_prod_u[63:32];
          r_lo <= w_prod_u[31:0];
        end
        c_fn_div: begin
          if (!w_div_zero) begin
            r_hi <= w_rem_s;
            r_lo <= w_quot_s;
          end
        end
        c_fn_divu: begin
          if (!w_div_zero) begin
            r_hi <= w_rem_u;
            r_lo <= w_quot_u;
          end
        end
        c_fn_mthi: r_hi <= rs_content;
        c_fn_mtlo: r_lo <= rs_content;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_2_pc_1.sv
// ---------------------------------------------------------------------------
// Module   : tb_alu_2_pc_1
// Brief    : Scoreboard bench for alu_2_pc_1 with directed vectors
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_2_pc_1;

  localparam int c_sel_alu  = 0;
  localparam int c_sel_br   = 1;
  localparam int c_sel_badr = 2;
  localparam int c_sel_pc   = 3;
  localparam int c_sel_pc4  = 4;
  localparam int c_sel_hi   = 5;
  localparam int c_sel_lo   = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] PCin;
  logic [31:0] PCout;
  logic [31:0] PCplus4;
  logic [5:0]  opcode;
  logic [5:0]  functcode;
  logic [4:0]  shamt;
  logic [4:0]  rt_field;
  logic [15:0] immediate;
  logic [31:0] rs_content;
  logic [31:0] rt_content;
  logic [31:0] ALU_result;
  logic        sig_branch;
  logic [31:0] branch_address;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_2_pc_1 u_dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .PCin           (PCin),
    .PCout          (PCout),
    .PCplus4        (PCplus4),
    .opcode         (opcode),
    .functcode      (functcode),
    .shamt          (shamt),
    .rt_field       (rt_field),
    .immediate      (immediate),
    .rs_content     (rs_content),
    .rt_content     (rt_content),
    .ALU_result     (ALU_result),
    .sig_branch     (sig_branch),
    .branch_address (branch_address),
    .HI             (HI),
    .LO             (LO)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      c_sel_alu:  return ALU_result;
      c_sel_br:   return {31'h0, sig_branch};
      c_sel_badr: return branch_address;
      c_sel_pc:   return PCout;
      c_sel_pc4:  return PCplus4;
      c_sel_hi:   return HI;
      default:    return LO;
    endcase
  endfunction

  // Monitor: everything queued since the last edge is checked mid-cycle.
  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e   = q_exp.pop_front();
      got = observe(e.sel);
      n_tests++;
      if (got !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.val);
      end
    end
  end

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q_exp.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sa);
    opcode     = 6'h00;
    functcode  = fn;
    rs_content = rs;
    rt_content = rt;
    shamt      = sa;
  endtask

  task automatic itype(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic [4:0] rtf);
    opcode     = op;
    functcode  = 6'h00;
    rs_content = rs;
    rt_content = rt;
    immediate  = imm;
    rt_field   = rtf;
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b0; PCin = 32'h0;
    opcode = 6'h3F; functcode = 6'h00; shamt = 5'd0; rt_field = 5'd0;
    immediate = 16'h0; rs_content = 32'h0; rt_content = 32'h0;

    cycle();
    push("reset_pc", c_sel_pc, 32'hBFC0_0000);
    push("reset_pc4", c_sel_pc4, 32'hBFC0_0004);
    push("reset_hi", c_sel_hi, 32'h0);
    push("reset_lo", c_sel_lo, 32'h0);
    reset = 1'b0; clk_enable = 1'b1; PCin = 32'h100;
    cycle();
    push("pc_load", c_sel_pc, 32'h100);
    clk_enable = 1'b0; PCin = 32'h200;
    cycle();
    push("pc_hold", c_sel_pc, 32'h100);

    rtype(6'h21, 32'hFFFF_FFFF, 32'h1, 5'd0); push("addu_wrap", c_sel_alu, 32'h0); cycle();
    rtype(6'h2A, 32'hFFFF_FFFF, 32'h1, 5'd0); push("slt", c_sel_alu, 32'h1); cycle();
    rtype(6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd0); push("sltu", c_sel_alu, 32'h0); cycle();
    rtype(6'h03, 32'h0, 32'h8000_0000, 5'd4); push("sra", c_sel_alu, 32'hF800_0000); cycle();
    rtype(6'h06, 32'h24, 32'h8000_0000, 5'd0); push("srlv", c_sel_alu, 32'h0800_0000); cycle();
    rtype(6'h27, 32'h0F0F_0000, 32'h0000_00FF, 5'd0); push("nor", c_sel_alu, 32'hF0F0_FF00); cycle();
    rtype(6'h22, 32'h5, 32'h7, 5'd0); push("sub", c_sel_alu, 32'hFFFF_FFFE); cycle();
    rtype(6'h09, 32'h0, 32'h0, 5'd0); push("jalr_link", c_sel_alu, 32'h108); cycle();
    rtype(6'h08, 32'h55, 32'h0, 5'd0); push("jr_zero", c_sel_alu, 32'h0); cycle();

    itype(6'h04, 32'h5, 32'h5, 16'hFFFF, 5'd0);
    push("beq_taken", c_sel_br, 32'h1);
    push("beq_target", c_sel_badr, 32'h100);
    cycle();
    itype(6'h05, 32'h5, 32'h5, 16'hFFFF, 5'd0); push("bne_not", c_sel_br, 32'h0); cycle();
    itype(6'h01, 32'h0, 32'h0, 16'h0004, 5'd1);
    push("bgez_zero", c_sel_br, 32'h1);
    push("bgez_target", c_sel_badr, 32'h114);
    cycle();
    itype(6'h01, 32'h8000_0000, 32'h0, 16'h0, 5'h10);
    push("bltzal_br", c_sel_br, 32'h1);
    push("bltzal_link", c_sel_alu, 32'h108);
    cycle();
    itype(6'h06, 32'h0, 32'h0, 16'h0, 5'd0); push("blez_zero", c_sel_br, 32'h1); cycle();
    itype(6'h07, 32'h0, 32'h0, 16'h0, 5'd0); push("bgtz_zero", c_sel_br, 32'h0); cycle();
    itype(6'h23, 32'h1000, 32'h0, 16'hFFFC, 5'd0); push("lw_addr", c_sel_alu, 32'h0FFC); cycle();
    itype(6'h0F, 32'h0, 32'h0, 16'hABCD, 5'd0); push("lui", c_sel_alu, 32'hABCD_0000); cycle();
    itype(6'h0D, 32'h0, 32'h0, 16'h8000, 5'd0); push("ori_zext", c_sel_alu, 32'h0000_8000); cycle();
    itype(6'h0B, 32'h5, 32'h0, 16'hFFFF, 5'd0); push("sltiu_sext", c_sel_alu, 32'h1); cycle();
    itype(6'h3F, 32'h5, 32'h5, 16'h1234, 5'd0); push("unknown_op", c_sel_alu, 32'h0); cycle();

    PCin = 32'h100; clk_enable = 1'b1;
    rtype(6'h18, 32'hFFFF_FFFD, 32'h7, 5'd0);
    cycle();
    clk_enable = 1'b0;
    push("mult_hi", c_sel_hi, 32'hFFFF_FFFF);
    push("mult_lo", c_sel_lo, 32'hFFFF_FFEB);
    rtype(6'h10, 32'h0, 32'h0, 5'd0); push("mfhi_after_mult", c_sel_alu, 32'hFFFF_FFFF);
    cycle();

    clk_enable = 1'b1; rtype(6'h19, 32'hFFFF_FFFF, 32'h2, 5'd0); cycle();
    clk_enable = 1'b0;
    push("multu_hi", c_sel_hi, 32'h1);
    push("multu_lo", c_sel_lo, 32'hFFFF_FFFE);
    cycle();

    clk_enable = 1'b1; rtype(6'h1A, 32'hFFFF_FFF9, 32'h2, 5'd0); cycle();
    clk_enable = 1'b0;
    push("div_lo", c_sel_lo, 32'hFFFF_FFFD);
    push("div_hi", c_sel_hi, 32'hFFFF_FFFF);
    cycle();

    clk_enable = 1'b1; rtype(6'h1B, 32'h1234_5678, 32'h0, 5'd0); cycle();
    clk_enable = 1'b0;
    push("divu0_hi", c_sel_hi, 32'hFFFF_FFFF);
    push("divu0_lo", c_sel_lo, 32'hFFFF_FFFD);
    cycle();

    clk_enable = 1'b1; rtype(6'h1B, 32'd100, 32'd7, 5'd0); cycle();
    clk_enable = 1'b0;
    push("divu_lo", c_sel_lo, 32'd14);
    push("divu_hi", c_sel_hi, 32'd2);
    cycle();

    clk_enable = 1'b1; rtype(6'h11, 32'h1234, 32'h0, 5'd0); cycle();
    clk_enable = 1'b0;
    rtype(6'h10, 32'h0, 32'h0, 5'd0); push("mthi_mfhi", c_sel_alu, 32'h1234);
    push("mthi_lo_kept", c_sel_lo, 32'd14);
    cycle();

    clk_enable = 1'b1; rtype(6'h13, 32'hCAFE_0001, 32'h0, 5'd0); cycle();
    clk_enable = 1'b0;
    rtype(6'h12, 32'h0, 32'h0, 5'd0); push("mtlo_mflo", c_sel_alu, 32'hCAFE_0001);
    cycle();

    // Held enable must not let a multiply land.
    rtype(6'h18, 32'h3, 32'h3, 5'd0); cycle();
    push("ce_low_hi", c_sel_hi, 32'h1234);
    push("ce_low_lo", c_sel_lo, 32'hCAFE_0001);
    cycle();

    reset = 1'b1; clk_enable = 1'b1; PCin = 32'h400;
    rtype(6'h18, 32'h3, 32'h3, 5'd0); cycle();
    reset = 1'b0; clk_enable = 1'b0;
    push("rst_prio_pc", c_sel_pc, 32'hBFC0_0000);
    push("rst_prio_hi", c_sel_hi, 32'h0);
    push("rst_prio_lo", c_sel_lo, 32'h0);
    cycle();

    for (int i = 0; i < 5 && q_exp.size() > 0; i++) cycle();
    if (q_exp.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
